// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from a 1-cycle-latency instruction memory and hands {pc, instr, fault} to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
  parameter logic [31:0] IMEM_LAST = 32'h0100_09FC,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);
  typedef enum logic {RUN, HALT} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        infl_fault_q, infl_fault_d;
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_instr_q [2];
  logic [1:0]  ent_fault_q;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        pop, push, issue, pc_legal, tail;
  logic [2:0]  occ;
  assign imem_addr = pc_q;
  assign out_valid = count_q != 2'd0;
  assign out_pc    = ent_pc_q[head_q];
  assign out_instr = ent_instr_q[head_q];
  assign out_fault = ent_fault_q[head_q];
  // Handshake, occupancy and issue qualification; a slot is issued only if it is guaranteed buffer room
  always_comb begin
    pop      = out_valid & out_ready;
    push     = inflight_q & ~redirect_valid;
    occ      = {1'b0, count_q} + {2'b0, inflight_q};
    pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= IMEM_BASE) && (pc_q <= IMEM_LAST);
    issue    = (state_q == RUN) && !redirect_valid && ((occ - {2'b0, pop}) < 3'd2);
    tail     = head_q ^ count_q[0];
  end
  // Fetch state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end
  // Redirect always restarts fetch; issuing a fault slot parks the unit until the next redirect
  always_comb begin
    state_d = redirect_valid ? RUN : (issue && !pc_legal) ? HALT : state_q;
  end
  // Memory read strobe; held low while reset is asserted so nothing is fetched during reset
  always_comb begin
    imem_rd = rst_n & issue & pc_legal;
  end
  // Next-state for PC, in-flight slot and buffer pointers
  always_comb begin
    pc_d         = redirect_valid ? redirect_pc : (issue && pc_legal) ? pc_q + 32'd4 : pc_q;
    inflight_d   = issue;
    infl_pc_d    = issue ? pc_q : infl_pc_q;
    infl_fault_d = issue ? !pc_legal : infl_fault_q;
    count_d      = redirect_valid ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    head_d       = redirect_valid ? 1'b0 : head_q ^ pop;
  end
  // PC, in-flight slot and buffer pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      infl_pc_q    <= '0;
      infl_fault_q <= 1'b0;
      count_q      <= '0;
      head_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      infl_pc_q    <= infl_pc_d;
      infl_fault_q <= infl_fault_d;
      count_q      <= count_d;
      head_q       <= head_d;
    end
  end
  // Arriving slot lands at the tail; fault slots carry a NOP instead of the (unread) memory data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_pc_q[0]    <= '0;
      ent_pc_q[1]    <= '0;
      ent_instr_q[0] <= '0;
      ent_instr_q[1] <= '0;
      ent_fault_q    <= '0;
    end else if (push) begin
      ent_pc_q[tail]    <= infl_pc_q;
      ent_instr_q[tail] <= infl_fault_q ? NOP_INSTR : imem_instr;
      ent_fault_q[tail] <= infl_fault_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a program-order reference model
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0, out_fault;
  logic [31:0] out_pc, out_instr;
  logic        rd_s;
  logic [31:0] addr_s;
  int n_chk = 0, n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a >= 32'h0100_0000 && a <= 32'h0100_09FC;
  endfunction

  always @(negedge clk) begin
    rd_s   = imem_rd;
    addr_s = imem_addr;
  end

  always @(posedge clk) imem_instr <= rd_s ? mem_f(addr_s) : $urandom;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    cyc; cyc;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    cyc;
    @(negedge clk);
    n_chk++;
    if ({imem_rd, out_valid, out_fault} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got rd/valid/fault=%b required 000", {imem_rd, out_valid, out_fault});
    end
    n_chk++;
    if ({out_pc, out_instr} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got pc=%h instr=%h required 0/0", out_pc, out_instr);
    end
    n_chk++;
    if (imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_addr: got %h required %h", imem_addr, RST_PC);
    end
    cyc;
  endtask

  task automatic test_fetch;
    logic [31:0] p;
    do_reset;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if ({out_valid, imem_rd, imem_addr} !== {1'b0, 1'b1, RST_PC + 32'(4 * c)}) begin
        n_fail++; $display("FAIL fetch_start c%0d: got valid=%b rd=%b addr=%h required 0 1 %h", c, out_valid, imem_rd, imem_addr, RST_PC + 32'(4 * c));
      end
      cyc;
    end
    for (int k = 0; k < 8; k++) begin
      p = RST_PC + 32'(4 * k);
      @(negedge clk);
      n_chk++;
      if ({out_valid, out_fault, out_pc, out_instr} !== {2'b10, p, mem_f(p)}) begin
        n_fail++; $display("FAIL fetch_stream k%0d: got v=%b f=%b pc=%h instr=%h required 1 0 %h %h", k, out_valid, out_fault, out_pc, out_instr, p, mem_f(p));
      end
      n_chk++;
      if ({imem_rd, imem_addr} !== {1'b1, p + 32'd8}) begin
        n_fail++; $display("FAIL fetch_issue k%0d: got rd=%b addr=%h required 1 %h", k, imem_rd, imem_addr, p + 32'd8);
      end
      cyc;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] p;
    do_reset;
    out_ready = 1'b1;
    cyc; cyc;
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_pc} !== {1'b1, RST_PC}) begin
      n_fail++; $display("FAIL bp_first: got v=%b pc=%h required 1 %h", out_valid, out_pc, RST_PC);
    end
    cyc;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if ({imem_rd, out_valid, out_pc} !== {2'b01, RST_PC + 32'd4}) begin
        n_fail++; $display("FAIL bp_hold c%0d: got rd=%b v=%b pc=%h required 0 1 %h", c, imem_rd, out_valid, out_pc, RST_PC + 32'd4);
      end
      cyc;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      p = RST_PC + 32'(4 * (k + 1));
      @(negedge clk);
      n_chk++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, p, mem_f(p)}) begin
        n_fail++; $display("FAIL bp_release k%0d: got v=%b pc=%h instr=%h required 1 %h %h", k, out_valid, out_pc, out_instr, p, mem_f(p));
      end
      cyc;
    end
  endtask

  task automatic test_redirect;
    do_reset;
    out_ready = 1'b0;
    cyc; cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
    @(negedge clk);
    n_chk++;
    if ({imem_rd, out_valid} !== 2'b01) begin
      n_fail++; $display("FAIL redir_cycle: got rd=%b v=%b required 0 1", imem_rd, out_valid);
    end
    cyc;
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({out_valid, imem_rd, imem_addr} !== {2'b01, 32'h0100_0100}) begin
      n_fail++; $display("FAIL redir_flush: got v=%b rd=%b addr=%h required 0 1 01000100", out_valid, imem_rd, imem_addr);
    end
    cyc;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_gap: got v=%b required 0", out_valid);
    end
    cyc;
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0100_0100, mem_f(32'h0100_0100)}) begin
      n_fail++; $display("FAIL redir_first: got v=%b pc=%h instr=%h required 1 01000100 %h", out_valid, out_pc, out_instr, mem_f(32'h0100_0100));
    end
    cyc;
    out_ready = 1'b0;
    cyc; cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0200; out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0100_0104}) begin
      n_fail++; $display("FAIL redir_full_head: got v=%b pc=%h required 1 01000104", out_valid, out_pc);
    end
    cyc;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({out_valid, imem_rd, imem_addr} !== {2'b01, 32'h0100_0200}) begin
      n_fail++; $display("FAIL redir_full_flush: got v=%b rd=%b addr=%h required 0 1 01000200", out_valid, imem_rd, imem_addr);
    end
    cyc; cyc;
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0100_0200}) begin
      n_fail++; $display("FAIL redir_full_first: got v=%b pc=%h required 1 01000200", out_valid, out_pc);
    end
    cyc;
  endtask

  task automatic test_range_end;
    int got;
    logic [31:0] p;
    do_reset;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0100_09F0;
    cyc;
    redirect_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        p = 32'h0100_09F0 + 32'(4 * got);
        n_chk++;
        if ({out_pc, out_fault, out_instr} !== {p, got == 4, (got == 4) ? NOP : mem_f(p)}) begin
          n_fail++; $display("FAIL end_entry%0d: got pc=%h f=%b instr=%h required %h %b %h", got, out_pc, out_fault, out_instr, p, got == 4, (got == 4) ? NOP : mem_f(p));
        end
        got++;
      end
      cyc;
    end
    n_chk++;
    if (got != 5) begin
      n_fail++; $display("FAIL end_count: got %0d entries required 5", got);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if ({imem_rd, out_valid} !== 2'b00) begin
        n_fail++; $display("FAIL end_halt c%0d: got rd=%b v=%b required 0 0", c, imem_rd, out_valid);
      end
      cyc;
    end
    redirect_valid = 1'b1; redirect_pc = RST_PC;
    cyc;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({imem_rd, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++; $display("FAIL end_resume: got rd=%b addr=%h required 1 %h", imem_rd, imem_addr, RST_PC);
    end
    cyc; cyc;
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_fault, out_pc} !== {2'b10, RST_PC}) begin
      n_fail++; $display("FAIL end_resume_out: got v=%b f=%b pc=%h required 1 0 %h", out_valid, out_fault, out_pc, RST_PC);
    end
    cyc;
  endtask

  task automatic test_bad_redirect;
    logic [31:0] bad [2];
    bad[0] = 32'h0100_0002;
    bad[1] = 32'h00FF_FFFC;
    for (int i = 0; i < 2; i++) begin
      do_reset;
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = bad[i];
      cyc;
      redirect_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (imem_rd !== 1'b0) begin
        n_fail++; $display("FAIL bad%0d_issue: got rd=%b required 0", i, imem_rd);
      end
      cyc;
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL bad%0d_gap: got v=%b required 0", i, out_valid);
      end
      cyc;
      @(negedge clk);
      n_chk++;
      if ({out_valid, out_fault, out_pc, out_instr} !== {2'b11, bad[i], NOP}) begin
        n_fail++; $display("FAIL bad%0d_entry: got v=%b f=%b pc=%h instr=%h required 1 1 %h %h", i, out_valid, out_fault, out_pc, out_instr, bad[i], NOP);
      end
      cyc;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        n_chk++;
        if ({imem_rd, out_valid} !== 2'b00) begin
          n_fail++; $display("FAIL bad%0d_halt c%0d: got rd=%b v=%b required 0 0", i, c, imem_rd, out_valid);
        end
        cyc;
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    out_ready = 1'b0;
    cyc; cyc; cyc; cyc;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got v=%b required 1", out_valid);
    end
    cyc;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, imem_rd} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_now: got v=%b rd=%b required 0 0", out_valid, imem_rd);
    end
    cyc;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({imem_rd, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++; $display("FAIL rmid_restart: got rd=%b addr=%h required 1 %h", imem_rd, imem_addr, RST_PC);
    end
    cyc; cyc;
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, RST_PC, mem_f(RST_PC)}) begin
      n_fail++; $display("FAIL rmid_out: got v=%b pc=%h instr=%h required 1 %h %h", out_valid, out_pc, out_instr, RST_PC, mem_f(RST_PC));
    end
    cyc;
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, prev_pc, prev_instr;
    logic        halted, prev_hold, prev_fault, pop;
    int          outs, pops, r;
    do_reset;
    exp_pc = RST_PC; halted = 1'b0; prev_hold = 1'b0; outs = 0; pops = 0;
    prev_pc = '0; prev_instr = '0; prev_fault = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 49) == 0;
      r = $urandom_range(0, 7);
      redirect_pc = (r < 5) ? RST_PC + 32'($urandom_range(0, 32'h27F) << 2) :
                    (r == 5) ? 32'h0100_09F0 + 32'($urandom_range(0, 3) << 2) :
                    (r == 6) ? RST_PC + 32'($urandom_range(0, 32'h27F) << 2) + 32'($urandom_range(1, 3)) :
                               32'h00FF_FFF0 + 32'($urandom_range(0, 3) << 2);
      @(negedge clk);
      if (prev_hold) begin
        n_chk++;
        if ({out_valid, out_pc, out_instr, out_fault} !== {1'b1, prev_pc, prev_instr, prev_fault}) begin
          n_fail++; $display("FAIL rnd_stable c%0d: got v=%b pc=%h instr=%h required 1 %h %h", c, out_valid, out_pc, out_instr, prev_pc, prev_instr);
        end
      end
      if (imem_rd) begin
        n_chk++;
        if (!legal(imem_addr)) begin
          n_fail++; $display("FAIL rnd_rd_addr c%0d: got addr=%h required legal address", c, imem_addr);
        end
      end
      pop = out_valid & out_ready & ~redirect_valid;
      if (redirect_valid) begin
        n_chk++;
        if (imem_rd !== 1'b0) begin
          n_fail++; $display("FAIL rnd_redir_rd c%0d: got rd=%b required 0", c, imem_rd);
        end
        exp_pc = redirect_pc; halted = 1'b0; outs = 0;
      end else begin
        outs = outs + int'(imem_rd) - int'(pop && !out_fault);
        n_chk++;
        if (outs > 2) begin
          n_fail++; $display("FAIL rnd_occupancy c%0d: got %0d outstanding required <= 2", c, outs);
        end
      end
      if (pop) begin
        pops++;
        n_chk++;
        if (halted) begin
          n_fail++; $display("FAIL rnd_after_fault c%0d: got entry pc=%h required none", c, out_pc);
        end else if ({out_pc, out_fault, out_instr} !== {exp_pc, !legal(exp_pc), legal(exp_pc) ? mem_f(exp_pc) : NOP}) begin
          n_fail++; $display("FAIL rnd_entry c%0d: got pc=%h f=%b instr=%h required %h %b %h", c, out_pc, out_fault, out_instr, exp_pc, !legal(exp_pc), legal(exp_pc) ? mem_f(exp_pc) : NOP);
        end
        if (!legal(exp_pc)) halted = 1'b1;
        else exp_pc = exp_pc + 32'd4;
      end
      prev_hold = out_valid & ~out_ready & ~redirect_valid;
      prev_pc = out_pc; prev_instr = out_instr; prev_fault = out_fault;
      cyc;
    end
    redirect_valid = 1'b0;
    n_chk++;
    if (pops < 300) begin
      n_fail++; $display("FAIL rnd_throughput: got %0d accepted entries required >= 300", pops);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_backpressure;
    test_redirect;
    test_range_end;
    test_bad_redirect;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
